// File: rtl/qmem_ram_slave.sv
// qmem_ram_slave: single-port RAM slave terminating QMEM bus cycles.
// Inserts WS wait states before each ack/err, performs byte-selective writes,
// and registers full-word read data into dat_r one cycle after the ack.
// Optional feature macro: QMEM_RAM_ERR_EN. When it is defined, accesses with
// any address bit set above the RAM window end with err instead of ack.
// When it is not defined, the upper address bits alias onto the RAM.
module qmem_ram_slave #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8,
  parameter int MAW = 10,
  parameter int WS  = 0
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic           we,
  input  logic [QSW-1:0] sel,
  input  logic [QAW-1:0] adr,
  input  logic [QDW-1:0] dat_w,
  output logic [QDW-1:0] dat_r,
  output logic           ack,
  output logic           err
);

  // B is the number of byte-offset bits ignored in the word index.
  localparam int B  = $clog2(QSW);
  localparam int CW = (WS > 0) ? $clog2(WS + 1) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            terminal;
  logic            addr_err;
  logic [MAW-1:0]  idx;
  logic            unused_adr;

  logic [QDW-1:0]  mem [0:(1<<MAW)-1];

  assign idx = adr[MAW+B-1:B];

  // The byte-offset bits never select anything; fold them away here.
  assign unused_adr = ^adr;

`ifdef QMEM_RAM_ERR_EN
  assign addr_err = |adr[QAW-1:MAW+B];
`else
  assign addr_err = 1'b0;
`endif

  // The terminal slot is the only cycle in which the request is acted upon.
  assign terminal = cs && (cnt == CW'(WS));

  // Responses are suppressed while reset is held, even if cs is high.
  assign ack = rst && terminal && !addr_err;
  assign err = rst && terminal &&  addr_err;

  // State and wait-counter register; reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: count wait states, abort on cs drop, restart after terminal slot.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (terminal) begin
          cnt_next = '0;
        end else if (cs) begin
          state_next = ST_WAIT;
          cnt_next   = cnt + CW'(1);
        end
      end
      ST_WAIT: begin
        if (!cs) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (terminal) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // RAM write port: only the selected byte lanes change on a write ack.
  always_ff @(posedge clk) begin
    if (ack && we) begin
      for (int i = 0; i < QSW; i++) begin
        if (sel[i]) begin
          mem[idx][8*i +: 8] <= dat_w[8*i +: 8];
        end
      end
    end
  end

  // Read data register: loads the whole word on a read ack and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_r <= '0;
    end else if (ack && !we) begin
      dat_r <= mem[idx];
    end
  end

endmodule

// File: tb/tb_qmem_ram_slave.sv
// tb_qmem_ram_slave: scoreboard bench for qmem_ram_slave.
// Two instances are exercised: one with no wait states and one with three.
// Shared request signals feed both instances, and cur steers cs to the one under test.
module tb_qmem_ram_slave;

`ifdef QMEM_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  bit          cur;

  logic        cs0, cs1;
  logic [31:0] dat_r0, dat_r1;
  logic        ack0, ack1, err0, err1;
  logic        ack_u, err_u;
  logic [31:0] dat_r_u;

  logic [31:0] model [2][1024];
  logic [31:0] exp_r [2];
  logic [31:0] sb [$];

  int n_checks;
  int n_fail;

  assign cs0     = cs & ~cur;
  assign cs1     = cs &  cur;
  assign ack_u   = cur ? ack1 : ack0;
  assign err_u   = cur ? err1 : err0;
  assign dat_r_u = cur ? dat_r1 : dat_r0;

  qmem_ram_slave #(.QAW(32), .QDW(32), .QSW(4), .MAW(10), .WS(0)) dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(we), .sel(sel), .adr(adr),
    .dat_w(dat_w), .dat_r(dat_r0), .ack(ack0), .err(err0)
  );

  qmem_ram_slave #(.QAW(32), .QDW(32), .QSW(4), .MAW(10), .WS(3)) dut1 (
    .clk(clk), .rst(rst), .cs(cs1), .we(we), .sel(sel), .adr(adr),
    .dat_w(dat_w), .dat_r(dat_r1), .ack(ack1), .err(err1)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (dut%0d, t=%0t)", tag, got, expv, cur, $time);
    end
  endtask

  // Run one transfer on the selected instance, then check latency, response and data.
  task automatic apply_stimulus(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    automatic int  ws  = cur ? 3 : 0;
    automatic bit  oor = ERR_EN && (a[31:12] != 20'h0);
    automatic int  idx = int'(a[11:2]);
    automatic int  n;
    automatic bit  got_ack = 1'b0;
    automatic bit  got_err = 1'b0;
    automatic logic [31:0] popped;
    @(negedge clk);
    cs = 1'b1; we = w; sel = s; adr = a; dat_w = d;
    if (!w && !oor) sb.push_back(model[cur][idx]);
    for (n = 0; n <= 20; n++) begin
      #1;
      got_ack = ack_u;
      got_err = err_u;
      if (got_ack || got_err) break;
      @(negedge clk);
    end
    check_output("latency", n, ws);
    check_output("ack", {31'b0, got_ack}, {31'b0, !oor});
    check_output("err", {31'b0, got_err}, {31'b0, oor});
    @(posedge clk);
    #1;
    if (got_ack && w) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[cur][idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (got_ack && !w) begin
      if (sb.size() == 0) begin
        check_output("sb_empty", 32'd0, 32'd1);
      end else begin
        popped = sb.pop_front();
        check_output("rdata", dat_r_u, popped);
        exp_r[cur] = popped;
      end
    end else begin
      check_output("dat_r_hold", dat_r_u, exp_r[cur]);
    end
  endtask

  // Drop cs for one cycle and confirm there is no response.
  task automatic go_idle();
    @(negedge clk);
    cs = 1'b0;
    #1;
    check_output("idle_ack", {31'b0, ack_u}, 32'd0);
    check_output("idle_err", {31'b0, err_u}, 32'd0);
  endtask

  // Main sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; cs = 1'b1; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0; cur = 1'b0;
    exp_r[0] = '0;
    exp_r[1] = '0;

    // Reset state: no response even with cs high, read data cleared.
    #12;
    check_output("rst_ack0", {31'b0, ack0}, 32'd0);
    check_output("rst_err0", {31'b0, err0}, 32'd0);
    check_output("rst_dat0", dat_r0, 32'd0);
    check_output("rst_dat1", dat_r1, 32'd0);
    @(negedge clk);
    cs  = 1'b0;
    rst = 1'b1;

    // No wait states: basic write and read back.
    cur = 1'b0;
    apply_stimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    go_idle();
    apply_stimulus(1'b0, 4'hF, 32'h10, 32'h0);
    check_output("deadbeef", dat_r_u, 32'hDEADBEEF);
    go_idle();

    // Byte lanes, including a write with no lanes selected.
    apply_stimulus(1'b1, 4'hF, 32'h14, 32'h11223344);
    apply_stimulus(1'b1, 4'h2, 32'h14, 32'hAABBCCDD);
    apply_stimulus(1'b0, 4'h0, 32'h14, 32'h0);
    check_output("lane_merge", dat_r_u, 32'h1122CC44);
    apply_stimulus(1'b1, 4'h0, 32'h14, 32'h99999999);
    apply_stimulus(1'b0, 4'hF, 32'h17, 32'h0);
    check_output("sel0_write", dat_r_u, 32'h1122CC44);
    go_idle();

    // Back-to-back write then read of the same word.
    apply_stimulus(1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    apply_stimulus(1'b0, 4'hF, 32'h20, 32'h0);
    check_output("b2b", dat_r_u, 32'hCAFEF00D);
    go_idle();

    // Out-of-range access: err with the check enabled, aliasing onto word 0 otherwise.
    apply_stimulus(1'b1, 4'hF, 32'h0, 32'h0BADF00D);
    apply_stimulus(1'b1, 4'hF, 32'h1000, 32'h55AA55AA);
    apply_stimulus(1'b0, 4'hF, 32'h0, 32'h0);
    check_output("alias_w", dat_r_u, ERR_EN ? 32'h0BADF00D : 32'h55AA55AA);
    apply_stimulus(1'b0, 4'hF, 32'h1000, 32'h0);
    go_idle();

    // Three wait states: fill four words, then read them with cs held high.
    cur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 4'hF, 32'(i * 4), 32'h1111_1111 * (i + 1));
    end
    go_idle();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 4'hF, 32'(i * 4), 32'h0);
    end
    check_output("ws3_last", dat_r_u, 32'h4444_4444);
    go_idle();

    // Abort by dropping cs after two wait cycles.
    @(negedge clk);
    cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h4; dat_w = 32'hFFFF_FFFF;
    #1 check_output("abort_ack_c0", {31'b0, ack_u}, 32'd0);
    @(negedge clk);
    #1 check_output("abort_ack_c1", {31'b0, ack_u}, 32'd0);
    go_idle();
    apply_stimulus(1'b0, 4'hF, 32'h4, 32'h0);
    check_output("abort_ram", dat_r_u, 32'h2222_2222);
    go_idle();

    // Reset pulsed mid-wait: transfer dropped, read data cleared, RAM intact.
    @(negedge clk);
    cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; dat_w = 32'hFFFF_FFFF;
    #1 check_output("rstw_ack_c0", {31'b0, ack_u}, 32'd0);
    @(negedge clk);
    #1 check_output("rstw_ack_c1", {31'b0, ack_u}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur = 1'b0;
    #1;
    check_output("rst_cs_ack0", {31'b0, ack0}, 32'd0);
    check_output("rst_cs_ack1", {31'b0, ack1}, 32'd0);
    check_output("rst_mid_dat0", dat_r0, 32'd0);
    check_output("rst_mid_dat1", dat_r1, 32'd0);
    exp_r[0] = '0;
    exp_r[1] = '0;
    @(negedge clk);
    cs  = 1'b0;
    rst = 1'b1;
    cur = 1'b1;
    apply_stimulus(1'b0, 4'hF, 32'h8, 32'h0);
    check_output("rst_ram", dat_r_u, 32'h3333_3333);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qmem_ram_slave.md
# qmem_ram_slave

Synthesizable single-port RAM slave for the QMEM bus, sitting directly downstream of a QMEM master (CPU instruction/data port or bench master) and terminating its cycles. Accepts chip-selected read/write requests, inserts a programmable number of wait states, acknowledges each transfer, performs byte-selective writes and returns read data one cycle after the acknowledge. An optional address-range check terminates out-of-range cycles with `err` instead of `ack`.

## Interface
- `QAW`, 32, bus address width (byte address)
- `QDW`, 32, data width; multiple of 8
- `QSW`, `QDW/8`, byte-select width
- `MAW`, 10, RAM word-address width (depth = 2^MAW words)
- `WS`, 0, wait states inserted before `ack`/`err` (0..15)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cs`  in  1  chip-select, request valid
- `we`  in  1  1 = write, 0 = read
- `sel`  in  `QSW`  byte select, bit i enables byte i (`dat[8i+7:8i]`)
- `adr`  in  `QAW`  byte address
- `dat_w`  in  `QDW`  write data
- `dat_r`  out  `QDW`  read data
- `ack`  out  1  transfer accepted/completed
- `err`  out  1  transfer terminated with error

## Operation
- Word index = `adr[MAW+B-1:B]`, B = log2(`QSW`); `adr[B-1:0]` ignored.
- Wait counter `cnt`, width ceil(log2(`WS`+1)) (min 1). Terminal slot: `cs && cnt == WS`.
- States: IDLE (`cnt`=0, no request), WAIT (`cs` high, `cnt` < `WS`). IDLE->WAIT when `cs` && `WS`>0; WAIT increments `cnt` each cycle `cs` high; terminal slot returns `cnt` to 0.
- `ack`/`err` combinational: high only in terminal slot; never both high.
- Write: at the terminal-slot edge with `ack`, bytes with `sel[i]`=1 written from `dat_w`; others unchanged. `sel`=0 still acked, RAM unchanged.
- Read: at terminal-slot edge with `ack`, full word (ignores `sel`) registered into `dat_r`; `dat_r` holds until the next read ack.
- Back-to-back: `cs` held high after terminal slot starts a new transfer next cycle at `cnt`=0 (WS=0: one transfer per cycle).
- `cs` dropped in WAIT: abort, `cnt`->0, no RAM write, `dat_r` unchanged.
- Request signals sampled only in terminal slot; changes during WAIT not checked.
- RAM contents not reset.

## Timing
- Reset (`rst`=0, async): `cnt`=0, IDLE, `dat_r`=0; `ack`=`err`=0 while in reset regardless of `cs`.
- Reset asserted mid-WAIT: transfer dropped, no write, restarts from `cnt`=0 after release.
- WS=0: `ack` same cycle `cs` rises; read data on `dat_r` in cycle after `ack`.
- WS=N: `ack` in cycle N after `cs` first high (cycles 0..N-1 wait); read data cycle N+1.
- Write latency: RAM updated at the ack edge; a read issued next cycle returns new data.

## Configuration
- `QMEM_RAM_ERR_EN` defined: any of `adr[QAW-1:MAW+B]` nonzero -> terminal slot raises `err` (not `ack`), no write, `dat_r` unchanged; wait states still applied.
- Not defined: upper address bits ignored (aliasing/wrap-around), `err` tied 0.

## Test plan
- WS=0: write `adr`=0x10, `sel`=0xF, `dat_w`=0xDEADBEEF -> `ack` same cycle; read 0x10 -> `ack`, `dat_r`=0xDEADBEEF next cycle.
- Byte lanes: write 0x11223344 full, then write `sel`=0x2 data 0xAABBCCDD -> read returns 0x1122CC44; `sel`=0 write leaves it unchanged but acks.
- WS=3: `cs` held continuously for 4 reads 0x0..0xC -> `ack` every 4th cycle, 4 acks in 16 cycles, data in order.
- Abort/reset: WS=3 write, `cs` dropped after 2 cycles -> no ack, RAM unchanged; repeat with `rst` pulsed low mid-WAIT -> `ack`=0, `dat_r`=0, RAM unchanged.
- With `QMEM_RAM_ERR_EN`, MAW=10: read/write `adr`=0x1000 -> `err`=1, `ack`=0, no write; without macro -> `ack`, aliases word 0.
- Back-to-back WS=0: write 0x20 then read 0x20 on consecutive cycles -> read returns just-written value.
